rain_gauge_mc: RTL
==================

// Module: rain_gauge_mc
// PURPOSE
//  Multi-channel rain gauge: counts debounced nRain pulses on NUM_CH sensors.
//  Converts the selected channel's total to ddd.dd mm BCD with a sequential
//  double-dabble engine, replacing the wide combinational divider chain.
//  Sits between the sensor pins and the LCD/digit driver.
// PARAMETERS
//  NUM_CH             4      number of independent sensor channels
//  COUNT_W            16     pulse counter width per channel
//  DEBOUNCE_CYCLES    820    lock-out after an accepted edge (25 ms @ 32.768 kHz)
//  MM_X100_PER_PULSE  28     rain per pulse in 0.01 mm units
//  MAX_X100           99999  display saturation value (999.99 mm)
// PORTS
//  Clock        in   1                  system clock
//  Reset        in   1                  asynchronous reset, active-high
//  nStart       in   1                  synchronous clear of all channels, active-low
//  nClear       in   NUM_CH             per-channel synchronous clear, active-low
//  nRain        in   NUM_CH             raw sensor pulses, active-low, asynchronous
//  ch_sel       in   $clog2(NUM_CH)     channel shown on the BCD outputs
//  pulse_count  out  NUM_CH x COUNT_W   accepted pulse totals
//  overflow     out  NUM_CH             sticky: counter hit all-ones
//  rain_bcd     out  5 x 4              [4]=hundreds .. [0]=hundredths
//  bcd_valid    out  1                  rain_bcd matches the current ch_sel/count
// BEHAVIOUR
//  - Reset sets:
//      pulse_count=0, overflow=0, rain_bcd=0, bcd_valid=1, FSM=IDLE.
//      snapshot count=0, snapshot channel=0, synchronisers=1, lock-out counters=0.
//  - Per channel, nRain passes through a 2-flop synchroniser, then falling-edge detect.
//    This adds 3 cycles of latency from the pin to the pulse_count update.
//  - Edge accepted only when that channel's lock-out counter is 0.
//    On acceptance: count+1 and the lock-out counter loads DEBOUNCE_CYCLES.
//    The counter then decrements to 0. Edges seen while it is nonzero are dropped.
//  - At count == 2^COUNT_W-1, further edges do not wrap: the count holds and overflow=1.
//  - Clear priority per channel: Reset > nStart/nClear > edge.
//    A clear zeroes the count, overflow and lock-out counter. A coincident edge is lost.
//  - Converter FSM: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
//    IDLE: when pulse_count[ch_sel] != snapshot or ch_sel != snapshot channel:
//      capture both into the snapshot, drop bcd_valid, go to LOAD.
//    LOAD: bin = min(snapshot*MM_X100_PER_PULSE, MAX_X100). Product is
//      COUNT_W+5 bits wide; saturation compare is done at full width.
//    SHIFT: BIN_W = $clog2(MAX_X100+1) = 17 iterations, one per cycle.
//      Each iteration: add 3 to every BCD nibble >= 5, then shift left.
//    DONE: rain_bcd <= result, then IDLE.
//      bcd_valid <= 1 only if the snapshot still matches the live count and ch_sel;
//      otherwise IDLE restarts immediately.
//  - Latency: trigger to bcd_valid=1 is BIN_W+3 = 20 cycles.
//    rain_bcd holds the previous value until DONE; it never shows partial results.
//  - Changes during a conversion do not abort it. They are picked up on the next pass.
//  - ch_sel values >= NUM_CH select channel 0.
//  - Reset asserted mid-conversion returns everything to the reset values above.
// STRUCTURE
//  - rain_pkg holds: DIGITS=5, BIN_W, bcd_digit_t (logic [3:0]), conv_state_t enum,
//    default DEBOUNCE_CYCLES and MM_X100_PER_PULSE.
//  - Sub-module rain_channel: synchroniser, edge detect, lock-out, saturating counter.
//    Instantiated NUM_CH times via generate.
//  - Converter FSM and the double-dabble datapath stay in this module.
// TESTING
//  1 Reset only -> all pulse_count=0, rain_bcd=000.00, bcd_valid=1.
//  2 One nRain low pulse on ch0, ch_sel=0
//      -> pulse_count[0]=1 after 3 cycles; 20 cycles later rain_bcd=000.28, bcd_valid=1.
//  3 Bounce: 5 falling edges on ch1 within 800 cycles -> count=1.
//      A further edge at 830 cycles after the first -> count=2.
//  4 Preload ch2 to 3572 pulses, ch_sel=2 -> 3572*28=100016, displays 999.99.
//      Force count 65535 plus one edge -> count holds 65535, overflow[2]=1.
//  5 Toggle ch_sel 0->1 mid-conversion -> bcd_valid stays 0, then shows ch1 value.
//      nStart low with a coincident edge -> all counts 0, display 000.00.
//  6 Assert Reset during SHIFT -> next cycle outputs at reset values; no stale digits.

Source files
------------

// File: rtl/rain_pkg.sv
// Shared types and constants for the multi-channel rain gauge.
// Also holds the per-iteration BCD digit adjustment used by the converter.
package rain_pkg;

    localparam int unsigned DIGITS                = 5;
    localparam int unsigned BCD_W                 = DIGITS * 4;
    localparam int unsigned DEF_MAX_X100          = 99999;
    localparam int unsigned BIN_W                 = $clog2(DEF_MAX_X100 + 1);
    localparam int unsigned DEF_DEBOUNCE_CYCLES   = 820;
    localparam int unsigned DEF_MM_X100_PER_PULSE = 28;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } conv_state_t;

    // Double-dabble correction: every digit >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rain_channel.sv
// One sensor channel: pin synchroniser, falling-edge detect, debounce
// lock-out and a saturating pulse counter with sticky overflow.
module rain_channel
    import rain_pkg::*;
#(
    parameter int unsigned COUNT_W         = 16,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               clear,
    input  logic               rain_n,
    output logic [COUNT_W-1:0] count,
    output logic               overflow
);

    localparam int unsigned LOCK_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [1:0]        sync;
    logic              prev;
    logic [LOCK_W-1:0] lock;
    logic              fall;

    assign fall = prev & ~sync[1];

    // Clear beats edge; an edge landing on a clear cycle is discarded.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync     <= 2'b11;
            prev     <= 1'b1;
            lock     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            sync <= {sync[0], rain_n};
            prev <= sync[1];
            if (clear) begin
                lock     <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else if (fall && (lock == '0)) begin
                lock <= LOCK_W'(DEBOUNCE_CYCLES);
                if (count == COUNT_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (lock != '0) begin
                lock <= lock - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rain_gauge_mc.sv
// Multi-channel rain gauge: per-channel pulse counters plus a sequential
// double-dabble converter presenting the selected channel as ddd.dd mm BCD.
module rain_gauge_mc
    import rain_pkg::*;
#(
    parameter int unsigned NUM_CH            = 4,
    parameter int unsigned COUNT_W           = 16,
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned MM_X100_PER_PULSE = DEF_MM_X100_PER_PULSE,
    parameter int unsigned MAX_X100          = DEF_MAX_X100
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic                             nStart,
    input  logic [NUM_CH-1:0]                nClear,
    input  logic [NUM_CH-1:0]                nRain,
    input  logic [$clog2(NUM_CH)-1:0]        ch_sel,
    output logic [NUM_CH-1:0][COUNT_W-1:0]   pulse_count,
    output logic [NUM_CH-1:0]                overflow,
    output bcd_digit_t [DIGITS-1:0]          rain_bcd,
    output logic                             bcd_valid
);

    localparam int unsigned SEL_W  = $clog2(NUM_CH);
    localparam int unsigned PROD_W = COUNT_W + 5;
    localparam int unsigned ITER_W = $clog2(BIN_W + 1);

    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        rain_channel #(
            .COUNT_W         (COUNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .Clock    (Clock),
            .Reset    (Reset),
            .clear    (~nStart | ~nClear[i]),
            .rain_n   (nRain[i]),
            .count    (pulse_count[i]),
            .overflow (overflow[i])
        );
    end

    // Out-of-range selects fall back to channel 0.
    logic [SEL_W-1:0] sel_ch;
    if (NUM_CH == (1 << SEL_W)) begin : g_sel_full
        assign sel_ch = ch_sel;
    end else begin : g_sel_clamp
        assign sel_ch = (ch_sel < SEL_W'(NUM_CH)) ? ch_sel : '0;
    end

    conv_state_t       state, state_d;
    logic [COUNT_W-1:0] snap_count, snap_count_d;
    logic [SEL_W-1:0]  snap_ch, snap_ch_d;
    logic [BIN_W-1:0]  bin, bin_d;
    logic [BCD_W-1:0]  bcd, bcd_d;
    logic [ITER_W-1:0] iter, iter_d;
    logic [BCD_W-1:0]  rain_bcd_d;
    logic              bcd_valid_d;

    logic [COUNT_W-1:0] live_count;
    logic               stale;
    logic [PROD_W-1:0]  product;
    logic [BIN_W-1:0]   sat_bin;
    logic [BCD_W-1:0]   bcd_adj;

    assign live_count = pulse_count[sel_ch];
    assign stale      = (live_count != snap_count) || (sel_ch != snap_ch);
    assign product    = PROD_W'(snap_count) * PROD_W'(MM_X100_PER_PULSE);
    assign sat_bin    = (product > PROD_W'(MAX_X100)) ? BIN_W'(MAX_X100) : product[BIN_W-1:0];
    assign bcd_adj    = dd_adjust(bcd);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            snap_count <= '0;
            snap_ch    <= '0;
            bin        <= '0;
            bcd        <= '0;
            iter       <= '0;
            rain_bcd   <= '0;
            bcd_valid  <= 1'b1;
        end else begin
            state      <= state_d;
            snap_count <= snap_count_d;
            snap_ch    <= snap_ch_d;
            bin        <= bin_d;
            bcd        <= bcd_d;
            iter       <= iter_d;
            rain_bcd   <= rain_bcd_d;
            bcd_valid  <= bcd_valid_d;
        end
    end

    // Conversion runs to completion; a stale result is dropped and IDLE retriggers.
    always_comb begin
        state_d      = state;
        snap_count_d = snap_count;
        snap_ch_d    = snap_ch;
        bin_d        = bin;
        bcd_d        = bcd;
        iter_d       = iter;
        rain_bcd_d   = rain_bcd;
        bcd_valid_d  = bcd_valid;
        unique case (state)
            IDLE: begin
                if (stale) begin
                    snap_count_d = live_count;
                    snap_ch_d    = sel_ch;
                    bcd_valid_d  = 1'b0;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                bin_d   = sat_bin;
                bcd_d   = '0;
                iter_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d  = BCD_W'({bcd_adj, bin[BIN_W-1]});
                bin_d  = bin << 1;
                iter_d = iter + 1'b1;
                if (iter == ITER_W'(BIN_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rain_bcd_d  = bcd;
                bcd_valid_d = !stale;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
